seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexes a single hex-to-7-segment decoder across DIGITS common-anode digits.
//  Holds a shadow copy of the displayed value and scans the digits one at a time.
//  For each digit it drives the nibble into the decoder and asserts that digit's
//  active-low enable. A blanking gap between digits suppresses ghosting.
//  Sits between the CPU debug/register tap and the board display pins.
//  Value updates are applied only at frame boundaries, so a frame never shows mixed old/new digits.
// PARAMETERS
//  DIGITS    4      number of digits scanned; digit 0 = least-significant nibble
//  PRESCALE  50000  clock cycles per digit slot (blank + show); must be >= 2
//  BLANK     8      cycles at the start of each slot with all digits off; 1 <= BLANK < PRESCALE
// PORTS
//  clock        in   1          system clock; all logic on its rising edge
//  reset        in   1          synchronous, active-high reset
//  load         in   1          one-cycle strobe: capture value for display
//  value        in   4*DIGITS   packed hex digits; [3:0] = digit 0
//  lz_blank_en  in   1          1 = blank leading zeros (digit 0 is never blanked)
//  nibble       out  4          hex digit to drive into the decoder's 4-bit input
//  digit_sel    out  DIGITS     active-low digit enables; at most one bit low
//  seg_off      out  1          1 = top level forces segments to 7'b1111111 (all off)
//  frame_done   out  1          one-cycle pulse after each completed scan of all digits
// BEHAVIOUR
//  - All outputs are registered. Reset values:
//    digit_sel = all 1, seg_off = 1, nibble = 0, frame_done = 0.
//  - Reset also clears: shadow = 0, pending = 0, pend_v = 0, idx = 0, cnt = 0, state = S_BLANK.
//  - Reset asserted mid-scan: all of the above take effect at the next edge.
//    Any pending load is discarded.
//  - FSM S_BLANK -> S_SHOW when cnt == BLANK-1.
//    S_SHOW -> S_BLANK when cnt == PRESCALE-1.
//    On that edge: cnt <= 0 and idx <= idx+1, wrapping DIGITS-1 -> 0.
//  - cnt is 0..PRESCALE-1 and is not reset on the BLANK->SHOW transition.
//    Width = clog2(PRESCALE).
//  - Outputs per state, from the registered state:
//    - S_BLANK: digit_sel = all 1, seg_off = 1, nibble = shadow[idx] (pre-drive).
//    - S_SHOW, digit not blanked: digit_sel = ~(1 << idx), seg_off = 0, nibble = shadow[idx].
//  - Leading-zero blanking: digit i (i > 0) is blanked when lz_blank_en = 1 and
//    shadow digits DIGITS-1 down to i are all 0.
//    A blanked digit behaves as S_BLANK for its whole slot; slot timing is unchanged.
//  - Boundary cycle = S_SHOW && idx == DIGITS-1 && cnt == PRESCALE-1. On its edge:
//    - frame_done <= 1 for exactly one cycle.
//    - if load == 1 this cycle: shadow <= value; pend_v <= 0 (direct load wins).
//    - else if pend_v: shadow <= pending; pend_v <= 0.
//  - load on any non-boundary cycle: pending <= value, pend_v <= 1.
//    A later load before the boundary overwrites pending (last wins).
//  - The shadow value never changes mid-frame.
//  - Frame period = DIGITS*PRESCALE cycles.
//  - Each digit is enabled for PRESCALE-BLANK consecutive cycles.
//  - After reset release, the first enabled digit is digit 0, at cycle BLANK.
//  - lz_blank_en is sampled every cycle (not shadowed); a change takes effect in the next slot's outputs.
// TESTING  (DIGITS=4, PRESCALE=8, BLANK=2)
//  1. Hold reset 3 cycles, then release.
//     -> digit_sel = 4'b1111, seg_off = 1, frame_done = 0 during reset.
//     -> Cycles 2..7 after release: digit_sel = 4'b1110, nibble = 0.
//  2. load 16'h1A3F, wait for frame_done, then watch one frame.
//     -> Slots show nibble F, 3, A, 1 with digit_sel 1110, 1101, 1011, 0111.
//     -> Each digit is enabled for 6 cycles, preceded by 2 all-off cycles.
//  3. lz_blank_en = 1, value 16'h0005.
//     -> Digits 3, 2, 1: digit_sel = 1111 and seg_off = 1 for their whole slots.
//     -> Digit 0 shows 5.
//     -> value 16'h0000: only digit 0 is lit, showing 0.
//     -> value 16'h0100: digits 2, 1, 0 are lit.
//  4. Displaying 16'h2222, load 16'h1111 in slot 1.
//     -> Slots 1..3 still show 2; the next frame shows 1.
//     -> Two loads in the same frame: the last one is shown.
//     -> load on the boundary cycle: the new value is shown from the very next frame.
//  5. Assert reset while digit 2 is in S_SHOW with a load pending.
//     -> Next cycle all outputs hold reset values.
//     -> After release, digit 0 shows 0; the pending value is never displayed.
//  6. Free-run 5 frames.
//     -> frame_done pulses exactly every 32 cycles, 1 cycle wide.
//     -> digit_sel never has more than one low bit.
//     -> digit_sel is all 1 whenever seg_off = 1.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexes one hex-to-7-segment decoder across DIGITS common-anode
//   digits. A shadow copy of the displayed value is scanned one digit per slot.
//   Each slot starts with BLANK all-off cycles, followed by the digit being lit
//   for the rest of the slot. New values are committed only at frame boundaries,
//   so a frame never mixes old and new digits.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   load         in   one-cycle strobe: capture value for display
//   value        in   packed hex digits, [3:0] = digit 0
//   lz_blank_en  in   1 = blank leading zeros (digit 0 is never blanked)
//   nibble       out  hex digit for the decoder input (pre-driven during blank)
//   digit_sel    out  active-low digit enables, at most one bit low
//   seg_off      out  1 = force all segments off
//   frame_done   out  one-cycle pulse after each completed scan
module seven_seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic                lz_blank_en,
  output logic [3:0]          nibble,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                seg_off,
  output logic                frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK - 1);
  localparam logic [CW-1:0] CNT_SLOT_END  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(DIGITS - 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic [4*DIGITS-1:0] shadow, shadow_nx;
  logic [4*DIGITS-1:0] pending, pending_nx;
  logic                pend_v, pend_v_nx;
  logic                blank_slot, blank_slot_nx;
  logic                slot_end, boundary;

  logic [3:0]          nibble_nx;
  logic [DIGITS-1:0]   digit_sel_nx;
  logic                seg_off_nx;

  // Select nibble i of a packed value without an out-of-range part-select.
  function automatic logic [3:0] digit_of(input logic [4*DIGITS-1:0] v,
                                          input logic [IW-1:0]       i);
    logic [3:0] d;
    d = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == i) d = v[4*k +: 4];
    end
    return d;
  endfunction

  // Digit i is a leading zero when it and every more-significant digit are 0.
  function automatic logic lz_blanked(input logic [4*DIGITS-1:0] v,
                                      input logic [IW-1:0]       i,
                                      input logic                en);
    logic blk;
    blk = en && (i != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(i) && v[4*k +: 4] != 4'h0) blk = 1'b0;
    end
    return blk;
  endfunction

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    idx_nx        = idx;
    shadow_nx     = shadow;
    pending_nx    = pending;
    pend_v_nx     = pend_v;
    blank_slot_nx = blank_slot;
    slot_end      = 1'b0;
    boundary      = 1'b0;

    unique case (state)
      S_BLANK: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CNT_BLANK_END) state_nx = S_SHOW;
      end
      S_SHOW: begin
        if (cnt == CNT_SLOT_END) begin
          slot_end = 1'b1;
          state_nx = S_BLANK;
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = S_BLANK;
      end
    endcase

    boundary = slot_end && (idx == IDX_LAST);

    // A direct load on the boundary wins over anything already pending.
    if (boundary) begin
      if (load) begin
        shadow_nx = value;
        pend_v_nx = 1'b0;
      end else if (pend_v) begin
        shadow_nx = pending;
        pend_v_nx = 1'b0;
      end
    end else if (load) begin
      pending_nx = value;
      pend_v_nx  = 1'b1;
    end

    // Blanking is decided once per slot so a digit is off for its whole slot.
    if (slot_end) blank_slot_nx = lz_blanked(shadow_nx, idx_nx, lz_blank_en);

    // Outputs are registered from the next-state values so they line up
    // with the state register in the same cycle.
    nibble_nx    = digit_of(shadow_nx, idx_nx);
    digit_sel_nx = '1;
    seg_off_nx   = 1'b1;
    if (state_nx == S_SHOW && !blank_slot_nx) begin
      digit_sel_nx = ~(DIGITS'(1) << idx_nx);
      seg_off_nx   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_BLANK;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      pending    <= '0;
      pend_v     <= 1'b0;
      blank_slot <= 1'b0;
      nibble     <= 4'h0;
      digit_sel  <= '1;
      seg_off    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      shadow     <= shadow_nx;
      pending    <= pending_nx;
      pend_v     <= pend_v_nx;
      blank_slot <= blank_slot_nx;
      nibble     <= nibble_nx;
      digit_sel  <= digit_sel_nx;
      seg_off    <= seg_off_nx;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK=2.
module tb_seven_seg_scan_ctrl;

  localparam int D = 4;
  localparam int P = 8;
  localparam int B = 2;
  localparam int F = D * P;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        lz_blank_en;
  logic [3:0]  nibble;
  logic [3:0]  digit_sel;
  logic        seg_off;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clock      (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .lz_blank_en(lz_blank_en),
    .nibble     (nibble),
    .digit_sel  (digit_sel),
    .seg_off    (seg_off),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: position in time since reset decides slot and phase;
  // frame-boundary commits and leading-zero rules computed arithmetically.
  int          m_t     = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_disp  = 16'h0;
  logic [15:0] m_pend  = 16'h0;
  logic        m_pv    = 1'b0;
  logic        m_lz    = 1'b0;
  logic        m_fd    = 1'b0;

  always @(posedge clk) begin
    int          slot, pos;
    logic [15:0] upper;
    logic        lit;
    logic [3:0]  esel;
    if (reset) begin
      m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
      m_lz = 1'b0; m_fd = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_fd = (m_t % F == F - 1);
      if (m_fd) begin
        if (load) begin
          m_disp = value; m_pv = 1'b0;
        end else if (m_pv) begin
          m_disp = m_pend; m_pv = 1'b0;
        end
      end else if (load) begin
        m_pend = value; m_pv = 1'b1;
      end
      if (m_t % P == P - 1) m_lz = lz_blank_en;
      m_t++;
    end
    if (m_valid) begin
      #1;
      slot  = (m_t / P) % D;
      pos   = m_t % P;
      upper = m_disp >> (4 * slot);
      lit   = (pos >= B) && !(m_lz && slot > 0 && upper == 16'h0);
      esel  = 4'hF;
      if (lit) esel = ~(4'b0001 << slot);
      check("model_digit_sel", 16'(digit_sel), 16'(esel));
      check("model_seg_off", 16'(seg_off), 16'(!lit));
      check("model_nibble", 16'(nibble), 16'(upper[3:0]));
      check("model_frame_done", 16'(frame_done), 16'(m_fd));
      check("one_low_max", 16'($countones(~digit_sel) <= 1), 16'h1);
      check("off_means_all_high", 16'(!seg_off || digit_sel == 4'hF), 16'h1);
    end
  end

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame_done", 16'(frame_done), 16'h1);
  endtask

  // Walk one whole frame from slot 0 phase 0 against hand-given digits/lit mask.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] mask);
    logic [3:0] esel;
    for (int s = 0; s < D; s++) begin
      for (int p = 0; p < P; p++) begin
        esel = 4'hF;
        if (p >= B && mask[s]) esel = ~(4'b0001 << s);
        check("frame_digit_sel", 16'(digit_sel), 16'(esel));
        check("frame_seg_off", 16'(seg_off), 16'(esel == 4'hF));
        check("frame_nibble", 16'(nibble), 16'(v[4*s +: 4]));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, pulses;
    reset = 1'b1; load = 1'b0; value = 16'h0; lz_blank_en = 1'b0;

    // Reset hold and release
    repeat (3) @(negedge clk);
    check("rst_digit_sel", 16'(digit_sel), 16'h000F);
    check("rst_seg_off", 16'(seg_off), 16'h0001);
    check("rst_frame_done", 16'(frame_done), 16'h0000);
    check("rst_nibble", 16'(nibble), 16'h0000);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k < B) check("rel_blank_sel", 16'(digit_sel), 16'h000F);
      else begin
        check("rel_digit0_sel", 16'(digit_sel), 16'h000E);
        check("rel_digit0_nib", 16'(nibble), 16'h0000);
      end
    end

    // Basic scan
    pulse_load(16'h1A3F);
    wait_frame();
    check_frame(16'h1A3F, 4'b1111);

    // Leading-zero blanking
    lz_blank_en = 1'b1;
    pulse_load(16'h0005);
    wait_frame();
    check_frame(16'h0005, 4'b0001);
    pulse_load(16'h0000);
    wait_frame();
    check_frame(16'h0000, 4'b0001);
    pulse_load(16'h0100);
    wait_frame();
    check_frame(16'h0100, 4'b0111);

    // Frame-boundary commit
    lz_blank_en = 1'b0;
    pulse_load(16'h2222);
    wait_frame();
    check_frame(16'h2222, 4'b1111);
    repeat (8) @(negedge clk);
    pulse_load(16'h1111);
    repeat (10) @(negedge clk);
    check("hold_old_value", 16'(nibble), 16'h0002);
    wait_frame();
    check_frame(16'h1111, 4'b1111);
    repeat (8) @(negedge clk);
    pulse_load(16'h3333);
    repeat (7) @(negedge clk);
    pulse_load(16'h4444);
    wait_frame();
    check_frame(16'h4444, 4'b1111);
    repeat (F - 1) @(negedge clk);
    value = 16'h5555;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("boundary_load_fd", 16'(frame_done), 16'h0001);
    check_frame(16'h5555, 4'b1111);

    // Reset mid-scan with a pending load
    pulse_load(16'h7777);
    repeat (19) @(negedge clk);
    check("pre_rst_digit2", 16'(digit_sel), 16'h000B);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_digit_sel", 16'(digit_sel), 16'h000F);
    check("midrst_seg_off", 16'(seg_off), 16'h0001);
    check("midrst_nibble", 16'(nibble), 16'h0000);
    check("midrst_frame_done", 16'(frame_done), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_sel", 16'(digit_sel), 16'h000E);
    check("post_rst_nib", 16'(nibble), 16'h0000);
    wait_frame();
    check_frame(16'h0000, 4'b1111);

    // Free run: frame_done period
    last = 0;
    pulses = 0;
    for (int i = 0; i <= 5 * F; i++) begin
      if (frame_done === 1'b1) begin
        if (i > 0) check("fd_period", 16'(i - last), 16'(F));
        last = i;
        pulses++;
      end
      @(negedge clk);
    end
    check("fd_pulse_count", 16'(pulses), 16'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
